spi_cmd_decoder: RTL and testbench

Command decoder downstream of the SPI slave receive shifter. Takes each completed 32-bit SPI frame (announced by a toggle from the receiver), decodes it into register-file operations on an NUM_REGS x 16-bit configuration bank, and returns read data on MISO during the following SPI transaction. Runs entirely in the SCLK domain; configuration outputs feed the SoC control logic.

---
 rtl/spi_cmd_decoder.sv | 153 +++++++++++++++
 tb/tb_spi_cmd_decoder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/spi_cmd_decoder.sv
// SPI frame decoder: turns each 32-bit frame into a write/set/clear/read on a 16-bit config bank.
// Register update lands 3 SCLK edges after the toggle is seen; one frame may queue behind an active op, and a further one is dropped and flagged in ovr.
module spi_cmd_decoder #(
    parameter int NUM_REGS = 8
) (
    input  logic                    reset,
    input  logic                    SCLK,
    input  logic                    SS,
    input  logic [31:0]             frame_data,
    input  logic                    frame_tog,
    output logic                    MISO,
    output logic [NUM_REGS*16-1:0]  cfg_flat,
    output logic                    wr_pulse,
    output logic [7:0]              wr_addr,
    output logic [7:0]              err_cnt,
    output logic                    ovr
);
    localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [3:0] OP_READ  = 4'h2;
    localparam logic [3:0] OP_SET   = 4'h3;
    localparam logic [3:0] OP_CLR   = 4'h4;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_SHIFT} state_t;

    state_t        r_state;
    logic          r_tog_s1, r_tog_s2, r_tog_s3;
    logic [31:0]   r_cmd;
    logic          r_pend;
    logic [15:0]   r_rd_shift;
    logic [3:0]    r_bit_cnt;
    logic [15:0]   r_cfg [NUM_REGS];
    logic          r_wr_pulse;
    logic [7:0]    r_wr_addr;
    logic [7:0]    r_err_cnt;
    logic          r_ovr;

    logic          w_new;
    logic [3:0]    w_op;
    logic [3:0]    w_rsv;
    logic [7:0]    w_addr;
    logic [15:0]   w_data;
    logic [AW-1:0] w_idx;
    logic          w_legal;
    logic          w_is_rd;
    logic [15:0]   w_cur;
    logic [15:0]   w_upd;

    assign w_new   = r_tog_s2 ^ r_tog_s3;
    assign w_op    = r_cmd[31:28];
    assign w_rsv   = r_cmd[27:24];
    assign w_addr  = r_cmd[23:16];
    assign w_data  = r_cmd[15:0];
    assign w_idx   = w_addr[AW-1:0];
    assign w_is_rd = (w_op == OP_READ);
    assign w_legal = (w_op inside {OP_WRITE, OP_READ, OP_SET, OP_CLR}) &&
                     (w_rsv == 4'h0) && ({1'b0, w_addr} < 9'(NUM_REGS));
    // Only meaningful when w_legal; the index is not range-checked here.
    assign w_cur   = r_cfg[w_idx];

    always_comb begin
        w_upd = w_data;
        case (w_op)
            OP_SET:  w_upd = w_cur | w_data;
            OP_CLR:  w_upd = w_cur & ~w_data;
            default: w_upd = w_data;
        endcase
    end

    always_ff @(posedge SCLK or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_tog_s1   <= 1'b0;
            r_tog_s2   <= 1'b0;
            r_tog_s3   <= 1'b0;
            r_cmd      <= '0;
            r_pend     <= 1'b0;
            r_rd_shift <= '0;
            r_bit_cnt  <= '0;
            r_wr_pulse <= 1'b0;
            r_wr_addr  <= '0;
            r_err_cnt  <= '0;
            r_ovr      <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) r_cfg[i] <= '0;
        end else begin
            r_tog_s1   <= frame_tog;
            r_tog_s2   <= r_tog_s1;
            r_tog_s3   <= r_tog_s2;
            r_wr_pulse <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_new) begin
                        r_cmd   <= frame_data;
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (!w_legal && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
                    if (w_is_rd) begin
                        r_rd_shift <= w_legal ? w_cur : 16'hDEAD;
                        r_bit_cnt  <= 4'd15;
                        r_state    <= S_SHIFT;
                        if (w_new) begin
                            r_cmd  <= frame_data;
                            r_pend <= 1'b1;
                        end
                    end else begin
                        if (w_legal) begin
                            r_cfg[w_idx] <= w_upd;
                            r_wr_pulse   <= 1'b1;
                            r_wr_addr    <= w_addr;
                        end
                        // EXEC is never entered with pending set, so a frame arriving now runs next.
                        if (w_new) begin
                            r_cmd   <= frame_data;
                            r_state <= S_EXEC;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_SHIFT: begin
                    if (w_new) begin
                        if (r_pend) r_ovr <= 1'b1;
                        else        r_cmd <= frame_data;
                    end
                    if (r_bit_cnt == 4'd0) begin
                        r_rd_shift <= '0;
                        r_pend     <= 1'b0;
                        r_state    <= (r_pend || w_new) ? S_EXEC : S_IDLE;
                    end else begin
                        r_rd_shift <= {r_rd_shift[14:0], 1'b0};
                        r_bit_cnt  <= r_bit_cnt - 4'd1;
                        if (w_new) r_pend <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign cfg_flat[16*g +: 16] = r_cfg[g];
    end

    assign MISO     = SS ? 1'b0 : r_rd_shift[15];
    assign wr_pulse = r_wr_pulse;
    assign wr_addr  = r_wr_addr;
    assign err_cnt  = r_err_cnt;
    assign ovr      = r_ovr;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed bench for spi_cmd_decoder: stimulus queues expected writes/reads, a negedge monitor checks them.
module tb_spi_cmd_decoder;
    localparam int NR = 8;

    logic          reset = 1'b0;
    logic          SCLK = 1'b0;
    logic          SS = 1'b0;
    logic [31:0]   frame_data = '0;
    logic          frame_tog = 1'b0;
    logic          MISO;
    logic [NR*16-1:0] cfg_flat;
    logic          wr_pulse;
    logic [7:0]    wr_addr;
    logic [7:0]    err_cnt;
    logic          ovr;

    spi_cmd_decoder #(.NUM_REGS(NR)) dut (
        .reset      (reset),
        .SCLK       (SCLK),
        .SS         (SS),
        .frame_data (frame_data),
        .frame_tog  (frame_tog),
        .MISO       (MISO),
        .cfg_flat   (cfg_flat),
        .wr_pulse   (wr_pulse),
        .wr_addr    (wr_addr),
        .err_cnt    (err_cnt),
        .ovr        (ovr)
    );

    always #5 SCLK = ~SCLK;

    int cyc = 0;
    always @(posedge SCLK) cyc++;

    typedef struct { int start; logic [15:0] exp; } rd_t;
    typedef struct { logic [7:0] addr; logic [15:0] val; } wr_t;
    rd_t rd_q[$];
    wr_t wr_q[$];
    rd_t mr;
    wr_t mw;
    logic [15:0] acc = '0;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [15:0] reg_of(input int a);
        return cfg_flat[16*a +: 16];
    endfunction

    // Monitor: checks every wr_pulse against the write queue and deserialises reads.
    always @(negedge SCLK) begin
        if (!reset) begin
            rd_q.delete();
        end else begin
            if (wr_pulse) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_wr_pulse", {120'd0, wr_addr}, 128'hFFFF);
                end else begin
                    mw = wr_q.pop_front();
                    chk("wr_addr", wr_addr, mw.addr);
                    chk("wr_data", reg_of(int'(mw.addr)), mw.val);
                end
            end
            if (rd_q.size() > 0 && cyc >= rd_q[0].start + 3) begin
                acc = {acc[14:0], MISO};
                if (cyc == rd_q[0].start + 18) begin
                    mr = rd_q.pop_front();
                    chk("read_word", acc, mr.exp);
                end
            end
        end
    end

    task automatic send(input logic [31:0] f, output int k);
        @(negedge SCLK);
        frame_data = f;
        frame_tog  = ~frame_tog;
        k = cyc + 1;
    endtask

    task automatic exp_wr(input logic [7:0] a, input logic [15:0] v);
        wr_t w;
        w.addr = a;
        w.val  = v;
        wr_q.push_back(w);
    endtask

    task automatic exp_rd(input int k, input logic [15:0] v);
        rd_t r;
        r.start = k;
        r.exp   = v;
        rd_q.push_back(r);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge SCLK);
    endtask

    logic [NR*16-1:0] exp_flat;

    initial begin
        int k;

        // reset state
        wait_cyc(3);
        chk("rst_miso", MISO, 0);
        chk("rst_cfg", cfg_flat, 0);
        chk("rst_wr_pulse", wr_pulse, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_ovr", ovr, 0);
        reset = 1'b1;
        wait_cyc(20);
        chk("idle_miso", MISO, 0);
        chk("idle_cfg", cfg_flat, 0);

        // write / set / clear on reg3
        send(32'h1003_A5A5, k); exp_wr(8'd3, 16'hA5A5); wait_cyc(6);
        send(32'h3003_000F, k); exp_wr(8'd3, 16'hA5AF); wait_cyc(6);
        send(32'h4003_A000, k); exp_wr(8'd3, 16'h05AF); wait_cyc(6);

        // read reg3; MISO forced low while SS high mid-read (bit 5 would be 1)
        send(32'h2003_0000, k); exp_rd(k, 16'h05AF);
        wait_cyc(9);
        #1 SS = 1'b1;
        #1 chk("miso_ss_high", MISO, 0);
        SS = 1'b0;
        wait_cyc(16);

        // rejected frames: bad opcode, nonzero reserved, out-of-range addr
        send(32'h7003_1234, k); wait_cyc(6);
        send(32'h1103_1234, k); wait_cyc(6);
        send(32'h1008_1234, k); wait_cyc(6);
        chk("err_cnt_3", err_cnt, 3);
        chk("reg3_untouched", reg_of(3), 16'h05AF);
        send(32'h2009_0000, k); exp_rd(k, 16'hDEAD); wait_cyc(22);
        chk("err_cnt_4", err_cnt, 4);

        // top address and zero-mask SET still pulse
        send(32'h1007_FFFF, k); exp_wr(8'd7, 16'hFFFF); wait_cyc(6);
        send(32'h3000_0000, k); exp_wr(8'd0, 16'h0000); wait_cyc(6);

        // saturate error counter
        for (int i = 0; i < 260; i++) begin
            send((i % 2) ? 32'h7000_0000 : 32'h0000_0000, k);
            wait_cyc(4);
        end
        chk("err_cnt_sat", err_cnt, 8'hFF);

        // overrun: read, one frame queued, one dropped
        chk("ovr_before", ovr, 0);
        send(32'h2007_0000, k); exp_rd(k, 16'hFFFF);
        wait_cyc(5);
        send(32'h1001_2345, k); exp_wr(8'd1, 16'h2345);
        wait_cyc(5);
        send(32'h1002_6789, k);
        wait_cyc(20);
        chk("ovr_after", ovr, 1);
        chk("reg2_dropped", reg_of(2), 16'h0000);
        chk("reg1_pending", reg_of(1), 16'h2345);

        // reset mid-read at bit 7
        send(32'h2001_0000, k); exp_rd(k, 16'h2345);
        wait_cyc(11);
        #2 reset = 1'b0;
        frame_tog = 1'b0;
        #1;
        chk("midrst_miso", MISO, 0);
        chk("midrst_cfg", cfg_flat, 0);
        chk("midrst_err", err_cnt, 0);
        chk("midrst_ovr", ovr, 0);
        chk("midrst_wr_addr", wr_addr, 0);
        wait_cyc(2);
        #2 reset = 1'b1;
        wait_cyc(3);
        send(32'h1005_BEEF, k); exp_wr(8'd5, 16'hBEEF); wait_cyc(6);
        exp_flat = '0;
        exp_flat[95:80] = 16'hBEEF;
        chk("post_rst_cfg", cfg_flat, exp_flat);
        chk("post_rst_miso", MISO, 0);

        wait_cyc(5);
        chk("wr_queue_drained", wr_q.size(), 0);
        chk("rd_queue_drained", rd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
